// File: rtl/button_debounce_in.sv
// Conditions a raw pushbutton pin into a debounced level, press/release pulses and
// an enable-gated toggle; everything downstream of the synchronizer is clean and synchronous.
module button_debounce_in #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 5,
    parameter bit ACTIVE_LOW      = 1'b1
) (
`ifdef PWR_PINS
    input  logic VDD,
    input  logic GND,
`endif
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 pin_norm;
    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 level_q;
    logic                 press_q;
    logic                 rel_q;
    logic                 toggle_q;
    logic                 differ;
    logic                 accept;

    // Polarity is folded in ahead of the synchronizer so every later stage sees 1 = pressed.
    assign pin_norm = btn_i ^ ACTIVE_LOW;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin_norm;
            sync2 <= sync1;
        end
    end

    assign differ = (sync2 != level_q);
    assign accept = differ && (cnt == CNT_LAST);

    // Any return to the stable level clears the count, so only an unbroken run qualifies.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (!differ || accept) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            press_q <= accept && sync2;
            rel_q   <= accept && !sync2;
            if (accept) begin
                level_q <= sync2;
            end
            if (accept && sync2 && en_i) begin
                toggle_q <= ~toggle_q;
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign toggle_o  = toggle_q;

endmodule

// File: tb/tb_button_debounce_in.sv
// Scoreboard bench for button_debounce_in (DEBOUNCE_CYCLES=4, active-low pin):
// stimulus queues expected pulses, a negedge monitor pops and compares them.
module tb_button_debounce_in;

    logic clk_i = 1'b0;
    logic rst_i;
    logic btn_i;
    logic en_i;
    logic level_o;
    logic press_o;
    logic release_o;
    logic toggle_o;

    typedef struct {
        bit   is_press;
        int   cyc;
        logic tog;
        logic lvl;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    button_debounce_in #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (5),
        .ACTIVE_LOW     (1'b1)
    ) dut (
`ifdef PWR_PINS
        .VDD      (1'b1),
        .GND      (1'b0),
`endif
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .btn_i    (btn_i),
        .en_i     (en_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .toggle_o (toggle_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input bit is_press, input int cyc, input logic tog, input logic lvl);
        exp_t e;
        e.is_press = is_press;
        e.cyc      = cyc;
        e.tog      = tog;
        e.lvl      = lvl;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Monitor: every pulse must match the head of the scoreboard in kind, cycle and side outputs.
    always @(negedge clk_i) begin
        exp_t e;
        chk("pulse_exclusive", press_o && release_o, 1'b0);
        if (press_o || release_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", press_o || release_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_press", press_o, e.is_press);
                chk_int("pulse_cycle", edge_n, e.cyc);
                chk("pulse_toggle", toggle_o, e.tog);
                chk("pulse_level", level_o, e.lvl);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation limit reached at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_i = 1'b1;
        btn_i = 1'b1;
        en_i  = 1'b1;
        wait_cycles(3);
        chk("rst_level", level_o, 1'b0);
        chk("rst_press", press_o, 1'b0);
        chk("rst_release", release_o, 1'b0);
        chk("rst_toggle", toggle_o, 1'b0);
        rst_i = 1'b0;
        wait_cycles(100);
        chk("idle_level", level_o, 1'b0);
        chk("idle_toggle", toggle_o, 1'b0);

        // Basic press: pin settles before edge n+1, level rises after edge n+6.
        btn_i = 1'b0;
        push(1'b1, edge_n + 6, 1'b1, 1'b1);
        wait_cycles(10);
        chk("held_level", level_o, 1'b1);
        chk("held_press_cleared", press_o, 1'b0);
        btn_i = 1'b1;
        push(1'b0, edge_n + 6, 1'b1, 1'b0);
        wait_cycles(10);
        chk("released_level", level_o, 1'b0);
        chk("released_toggle", toggle_o, 1'b1);

        // Three-clock glitch must be rejected.
        btn_i = 1'b0;
        wait_cycles(3);
        btn_i = 1'b1;
        wait_cycles(10);
        chk("glitch3_level", level_o, 1'b0);
        chk("glitch3_toggle", toggle_o, 1'b1);

        // Four-clock excursion is exactly long enough; its end then qualifies as a release.
        n = edge_n;
        btn_i = 1'b0;
        push(1'b1, n + 6, 1'b0, 1'b1);
        wait_cycles(4);
        btn_i = 1'b1;
        push(1'b0, n + 10, 1'b0, 1'b0);
        wait_cycles(12);

        // Enabled press toggles, disabled press does not.
        en_i  = 1'b1;
        btn_i = 1'b0;
        push(1'b1, edge_n + 6, 1'b1, 1'b1);
        wait_cycles(10);
        btn_i = 1'b1;
        push(1'b0, edge_n + 6, 1'b1, 1'b0);
        wait_cycles(10);
        en_i  = 1'b0;
        btn_i = 1'b0;
        push(1'b1, edge_n + 6, 1'b1, 1'b1);
        wait_cycles(10);
        btn_i = 1'b1;
        push(1'b0, edge_n + 6, 1'b1, 1'b0);
        wait_cycles(10);
        chk("en_off_toggle", toggle_o, 1'b1);
        en_i = 1'b1;

        // Reset mid-qualification: full requalification after release of reset.
        btn_i = 1'b0;
        wait_cycles(3);
        rst_i = 1'b1;
        wait_cycles(2);
        chk("midrst_level", level_o, 1'b0);
        chk("midrst_toggle", toggle_o, 1'b0);
        rst_i = 1'b0;
        push(1'b1, edge_n + 6, 1'b1, 1'b1);
        wait_cycles(10);
        btn_i = 1'b1;
        push(1'b0, edge_n + 6, 1'b1, 1'b0);
        wait_cycles(20);

        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
